// File: rtl/param_half_adder_pkg.sv
// Shared constants and helpers for the registered half-adder bank.
// Cell selection codes and a popcount used to total per-lane errors.
package param_half_adder_pkg;

    localparam int HA_EXACT  = 0;
    localparam int HA_APPROX = 1;

    // Widest lane vector popcount accepts; narrower vectors are zero-extended.
    localparam int POP_MAX_W = 256;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/param_half_adder_ha_cell.sv
// One half-adder lane: exact (a^b) or approximate (a|b) sum, exact carry, and error flag.
// Latency: purely combinational.
// Backpressure: none.
module ha_cell
    import param_half_adder_pkg::*;
#(
    parameter int APPROX = HA_EXACT
) (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry,
    output logic o_err
);

    logic w_exact_sum;
    logic w_cell_sum;

    assign w_exact_sum = i_a ^ i_b;

    // Any non-zero mode selects the OR cell, which only differs at a=b=1.
    generate
        if (APPROX == HA_EXACT) begin : g_exact
            assign w_cell_sum = w_exact_sum;
        end else begin : g_approx
            assign w_cell_sum = i_a | i_b;
        end
    endgenerate

    assign o_sum   = w_cell_sum;
    assign o_carry = i_a & i_b;
    assign o_err   = w_cell_sum ^ w_exact_sum;

endmodule

// File: rtl/param_half_adder.sv
// Registered bank of WIDTH half adders with per-lane error flags and a saturating error count.
// Latency: 1 cycle from in_valid to out_valid; no backpressure, one vector accepted per cycle.
module param_half_adder
    import param_half_adder_pkg::*;
#(
    parameter int APPROX = 0,
    parameter int WIDTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [WIDTH-1:0] err_lane,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             cnt_clr
);

    localparam int CELL_MODE = (APPROX == HA_EXACT) ? HA_EXACT : HA_APPROX;
    localparam int POP_W     = $clog2(WIDTH + 1);
    localparam int SUM_W     = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = (SUM_W'(1) << CNT_W) - SUM_W'(1);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_err;
    logic [POP_W-1:0] w_pop;
    logic [SUM_W-1:0] w_cnt_sum;
    logic [CNT_W-1:0] w_cnt_next;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_carry;
    logic [WIDTH-1:0] r_err_lane;
    logic [CNT_W-1:0] r_err_cnt;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            ha_cell #(
                .APPROX (CELL_MODE)
            ) u_cell (
                .i_a     (a[gi]),
                .i_b     (b[gi]),
                .o_sum   (w_sum[gi]),
                .o_carry (w_carry[gi]),
                .o_err   (w_err[gi])
            );
        end
    endgenerate

    // Sum is one bit wider than either operand so the saturation compare never overflows.
    assign w_pop      = POP_W'(popcount(POP_MAX_W'(w_err)));
    assign w_cnt_sum  = SUM_W'(r_err_cnt) + SUM_W'(w_pop);
    assign w_cnt_next = (w_cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_carry     <= '0;
            r_err_lane  <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum      <= w_sum;
                r_carry    <= w_carry;
                r_err_lane <= w_err;
            end
        end
    end

    // Clear wins over an accepted vector in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (cnt_clr) begin
            r_err_cnt <= '0;
        end else if (in_valid) begin
            r_err_cnt <= w_cnt_next;
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign carry     = r_carry;
    assign err_lane  = r_err_lane;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_param_half_adder.sv
// Bench: exact, approximate, out-of-range-mode and narrow-counter instances driven side by side
// and compared against an arithmetic model of the half-adder lanes.
module tb_param_half_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       cnt_clr;
    logic [3:0] a;
    logic [3:0] b;

    logic        ex_vld, ap_vld, ap2_vld, sat_vld;
    logic [3:0]  ex_sum, ex_carry, ex_err;
    logic [3:0]  ap_sum, ap_carry, ap_err;
    logic [3:0]  ap2_sum, ap2_carry, ap2_err;
    logic        sat_sum, sat_carry, sat_err;
    logic [15:0] ex_cnt, ap_cnt;
    logic [7:0]  ap2_cnt;
    logic [1:0]  sat_cnt;

    param_half_adder #(.APPROX(0), .WIDTH(4), .CNT_W(16)) u_ex (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(ex_vld), .sum(ex_sum), .carry(ex_carry), .err_lane(ex_err),
        .err_cnt(ex_cnt), .cnt_clr(cnt_clr));

    param_half_adder #(.APPROX(1), .WIDTH(4), .CNT_W(16)) u_ap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(ap_vld), .sum(ap_sum), .carry(ap_carry), .err_lane(ap_err),
        .err_cnt(ap_cnt), .cnt_clr(cnt_clr));

    param_half_adder #(.APPROX(2), .WIDTH(4), .CNT_W(8)) u_ap2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(ap2_vld), .sum(ap2_sum), .carry(ap2_carry), .err_lane(ap2_err),
        .err_cnt(ap2_cnt), .cnt_clr(cnt_clr));

    param_half_adder #(.APPROX(1), .WIDTH(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[0:0]), .b(b[0:0]),
        .out_valid(sat_vld), .sum(sat_sum), .carry(sat_carry), .err_lane(sat_err),
        .err_cnt(sat_cnt), .cnt_clr(cnt_clr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic       m_vld;
    logic [3:0] m_ex_s, m_ex_c, m_ex_e;
    logic [3:0] m_ap_s, m_ap_c, m_ap_e;
    int         m_ex_cnt, m_ap_cnt, m_ap2_cnt, m_sat_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=0x%0h exp=0x%0h", tag, $time, got, exp);
        end
    endtask

    // Lane arithmetic: t = a_i + b_i in {0,1,2}; carry is t/2, exact sum is t mod 2.
    function automatic void lane_model(input logic [3:0] va, input logic [3:0] vb, input bit approx,
                                       output logic [3:0] s, output logic [3:0] c, output logic [3:0] e);
        for (int i = 0; i < 4; i++) begin
            int t;
            bit exact_s;
            t       = int'(va[i]) + int'(vb[i]);
            exact_s = (t % 2) == 1;
            s[i]    = approx ? (t != 0) : exact_s;
            c[i]    = (t / 2) == 1;
            e[i]    = s[i] != exact_s;
        end
    endfunction

    function automatic int sat_add(input int cur, input int inc, input int maxv);
        return (cur + inc > maxv) ? maxv : cur + inc;
    endfunction

    task automatic model_reset();
        m_vld = 1'b0;
        m_ex_s = '0; m_ex_c = '0; m_ex_e = '0;
        m_ap_s = '0; m_ap_c = '0; m_ap_e = '0;
        m_ex_cnt = 0; m_ap_cnt = 0; m_ap2_cnt = 0; m_sat_cnt = 0;
    endtask

    task automatic model_update();
        logic [3:0] s, c, e;
        if (in_valid) begin
            lane_model(a, b, 1'b0, m_ex_s, m_ex_c, m_ex_e);
            lane_model(a, b, 1'b1, s, c, e);
            m_ap_s = s; m_ap_c = c; m_ap_e = e;
        end
        if (cnt_clr) begin
            m_ex_cnt = 0; m_ap_cnt = 0; m_ap2_cnt = 0; m_sat_cnt = 0;
        end else if (in_valid) begin
            m_ex_cnt  = sat_add(m_ex_cnt, $countones(m_ex_e), 65535);
            m_ap_cnt  = sat_add(m_ap_cnt, $countones(m_ap_e), 65535);
            m_ap2_cnt = sat_add(m_ap2_cnt, $countones(m_ap_e), 255);
            m_sat_cnt = sat_add(m_sat_cnt, int'(m_ap_e[0]), 3);
        end
        m_vld = in_valid;
    endtask

    task automatic check_all(input string pfx);
        check({pfx, ".ex_vld"},    64'(ex_vld),    64'(m_vld));
        check({pfx, ".ex_sum"},    64'(ex_sum),    64'(m_ex_s));
        check({pfx, ".ex_carry"},  64'(ex_carry),  64'(m_ex_c));
        check({pfx, ".ex_err"},    64'(ex_err),    64'(m_ex_e));
        check({pfx, ".ex_cnt"},    64'(ex_cnt),    64'(m_ex_cnt));
        check({pfx, ".ap_vld"},    64'(ap_vld),    64'(m_vld));
        check({pfx, ".ap_sum"},    64'(ap_sum),    64'(m_ap_s));
        check({pfx, ".ap_carry"},  64'(ap_carry),  64'(m_ap_c));
        check({pfx, ".ap_err"},    64'(ap_err),    64'(m_ap_e));
        check({pfx, ".ap_cnt"},    64'(ap_cnt),    64'(m_ap_cnt));
        check({pfx, ".ap2_sum"},   64'(ap2_sum),   64'(m_ap_s));
        check({pfx, ".ap2_err"},   64'(ap2_err),   64'(m_ap_e));
        check({pfx, ".ap2_cnt"},   64'(ap2_cnt),   64'(m_ap2_cnt));
        check({pfx, ".ap2_vld"},   64'(ap2_vld),   64'(m_vld));
        check({pfx, ".ap2_carry"}, 64'(ap2_carry), 64'(m_ap_c));
        check({pfx, ".sat_vld"},   64'(sat_vld),   64'(m_vld));
        check({pfx, ".sat_sum"},   64'(sat_sum),   64'(m_ap_s[0]));
        check({pfx, ".sat_carry"}, 64'(sat_carry), 64'(m_ap_c[0]));
        check({pfx, ".sat_err"},   64'(sat_err),   64'(m_ap_e[0]));
        check({pfx, ".sat_cnt"},   64'(sat_cnt),   64'(m_sat_cnt));
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, ".ex_vld"},  64'(ex_vld),  64'd0);
        check({pfx, ".ex_sum"},  64'(ex_sum),  64'd0);
        check({pfx, ".ex_cnt"},  64'(ex_cnt),  64'd0);
        check({pfx, ".ap_vld"},  64'(ap_vld),  64'd0);
        check({pfx, ".ap_sum"},  64'(ap_sum),  64'd0);
        check({pfx, ".ap_carry"},64'(ap_carry),64'd0);
        check({pfx, ".ap_err"},  64'(ap_err),  64'd0);
        check({pfx, ".ap_cnt"},  64'(ap_cnt),  64'd0);
        check({pfx, ".ap2_cnt"}, 64'(ap2_cnt), 64'd0);
        check({pfx, ".sat_cnt"}, 64'(sat_cnt), 64'd0);
    endtask

    // Inputs present at this edge are applied to the model, outputs checked 1 time unit later.
    task automatic step(input string pfx);
        @(posedge clk);
        model_update();
        #1;
        check_all(pfx);
    endtask

    logic [1:0] tt_ex [4];
    logic [1:0] tt_ap [4];
    int         cnt_before;

    initial begin
        tt_ex = '{2'b00, 2'b01, 2'b01, 2'b10};
        tt_ap = '{2'b00, 2'b01, 2'b01, 2'b11};

        rst_n = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0; a = '0; b = '0;
        model_reset();
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Truth table on lane 0
        for (int k = 0; k < 4; k++) begin
            logic [1:0] ab;
            ab = 2'(k);
            a = {3'b000, ab[1]}; b = {3'b000, ab[0]}; in_valid = 1'b1;
            step("tt");
            check("tt_ex_cs", 64'({ex_carry[0], ex_sum[0]}), 64'(tt_ex[k]));
            check("tt_ap_cs", 64'({ap_carry[0], ap_sum[0]}), 64'(tt_ap[k]));
            check("tt_sat_err", 64'(sat_err), 64'(k == 3));
        end
        check("tt_sat_cnt", 64'(sat_cnt), 64'd1);

        // Four-lane approximate vector
        cnt_before = m_ap_cnt;
        a = 4'b1111; b = 4'b1010; in_valid = 1'b1;
        step("w4");
        check("w4_sum",   64'(ap_sum),   64'(4'b1111));
        check("w4_carry", 64'(ap_carry), 64'(4'b1010));
        check("w4_err",   64'(ap_err),   64'(4'b1010));
        check("w4_cnt",   64'(ap_cnt),   64'(cnt_before + 2));

        // Saturation of the 2-bit counter, then clear racing an error
        cnt_clr = 1'b1; in_valid = 1'b0;
        step("clr");
        cnt_clr = 1'b0;
        a = 4'b0001; b = 4'b0001; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) step("sat");
        check("sat_stick", 64'(sat_cnt), 64'd3);
        cnt_clr = 1'b1;
        step("clr_err");
        check("sat_clr_prio", 64'(sat_cnt), 64'd0);
        cnt_clr = 1'b0;

        // Idle gap holds data, drops valid
        a = 4'b0110; b = 4'b0011; in_valid = 1'b1;
        step("pre_gap");
        in_valid = 1'b0; a = 4'b1111; b = 4'b1111;
        step("gap1");
        step("gap2");
        check("gap_hold_sum", 64'(ex_sum), 64'(4'b0101));

        // Asynchronous reset in the middle of a cycle with a vector in flight
        a = 4'b1011; b = 4'b1101; in_valid = 1'b1;
        step("inflight");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_zero("mid_rst");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst");

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            a        = 4'($urandom);
            b        = 4'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            cnt_clr  = ($urandom_range(0, 15) == 0);
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
